uart_frame_rx: RTL and testbench

Parametrised UART frame receiver that turns a serial byte stream into validated fixed-length payload words for the DDS control registers. It contains its own mid-bit-sampling byte receiver, a frame FSM (header, payload, optional CRC8, tail) with inter-byte timeout, and error reporting. It sits directly behind the board UART pin and feeds the register/decode logic with a single-cycle `frame_valid` strobe.

---
 rtl/uart_frame_rx_if.sv | 30 +++
 rtl/uart_frame_rx.sv | 232 +++++++++++++++++++++++
 tb/tb_uart_frame_rx.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_frame_rx_if.sv
// Bundle of the serial input and the parsed-frame outputs of uart_frame_rx.
// frame_state is a debug view of the frame FSM encoding.
interface uart_frame_rx_if #(
    parameter int PAYLOAD_LEN = 11
);
    // Strobe protocol: byte_valid, frame_valid and frame_err are one-cycle
    // pulses with no ready/backpressure; the consumer must take data in that cycle.
    logic                     uart_rxd;
    logic [7:0]               byte_data;
    logic                     byte_valid;
    logic [8*PAYLOAD_LEN-1:0] payload;
    logic                     frame_valid;
    logic                     frame_err;
    logic [1:0]               err_code;
    logic [7:0]               err_cnt;
    logic                     busy;
    logic [1:0]               frame_state;

    modport master (
        input  uart_rxd,
        output byte_data, byte_valid, payload, frame_valid, frame_err,
               err_code, err_cnt, busy, frame_state
    );

    modport slave (
        output uart_rxd,
        input  byte_data, byte_valid, payload, frame_valid, frame_err,
               err_code, err_cnt, busy, frame_state
    );
endinterface

// File: rtl/uart_frame_rx.sv
// UART byte receiver plus HEADER / payload / [CRC8] / TAIL frame parser with timeout.
// Define UART_FRAME_CRC_EN to include the CRC8 byte between payload and tail.
module uart_frame_rx #(
    parameter int         CLK_FREQ     = 50_000_000,
    parameter int         UART_BPS     = 115200,
    parameter int         PAYLOAD_LEN  = 11,
    parameter logic [7:0] HEADER       = 8'h55,
    parameter logic [7:0] TAIL         = 8'hAA,
    parameter int         TIMEOUT_BITS = 20
) (
    input  logic            sys_clk,
    input  logic            sys_rst_n,
    uart_frame_rx_if.master bus
);
    localparam int BPS_CNT = CLK_FREQ / UART_BPS;
    localparam int MID     = BPS_CNT / 2;
    localparam int CNT_W   = $clog2(BPS_CNT + 1);
    localparam int TO_LIM  = TIMEOUT_BITS * BPS_CNT;
    localparam int TO_W    = $clog2(TO_LIM + 1);
    localparam int IDX_W   = (PAYLOAD_LEN > 1) ? $clog2(PAYLOAD_LEN) : 1;
    localparam int PW      = 8 * PAYLOAD_LEN;

`ifdef UART_FRAME_CRC_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_PAYLOAD = 2'd1, S_CRC = 2'd2, S_TAIL = 2'd3} state_t;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_PAYLOAD = 2'd1, S_TAIL = 2'd3} state_t;
`endif

    logic             rxd_s1, rxd_s2, rxd_d;
    logic             start_edge;
    logic             rx_active;
    logic [CNT_W-1:0] clk_cnt;
    logic [3:0]       bit_idx;
    logic [7:0]       shift;
    logic             byte_valid_r;
    logic [7:0]       byte_data_r;
    logic             stop_err_evt;

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [TO_W-1:0]  to_cnt;
    logic [PW-1:0]    shadow;
    logic [PW-1:0]    payload_r;
    logic             frame_valid_r;
    logic             frame_err_r;
    logic [1:0]       err_code_r;
    logic [7:0]       err_cnt_r;
    logic             abort;
    logic [1:0]       abort_code;
    logic             byte_evt;
`ifdef UART_FRAME_CRC_EN
    logic [7:0]       crc;

    function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] r;
        r = c ^ d;
        for (int i = 0; i < 8; i++) begin
            r = r[7] ? ({r[6:0], 1'b0} ^ 8'h07) : {r[6:0], 1'b0};
        end
        return r;
    endfunction
`endif

    // Synchroniser idles high so reset release never looks like a start edge.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rxd_s1 <= 1'b1;
            rxd_s2 <= 1'b1;
            rxd_d  <= 1'b1;
        end else begin
            rxd_s1 <= bus.uart_rxd;
            rxd_s2 <= rxd_s1;
            rxd_d  <= rxd_s2;
        end
    end

    assign start_edge = rxd_d & ~rxd_s2;

    // bit_idx: 0 start, 1..8 data LSB first, 9 stop. Hunt resumes at mid stop bit.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rx_active    <= 1'b0;
            clk_cnt      <= '0;
            bit_idx      <= '0;
            shift        <= '0;
            byte_valid_r <= 1'b0;
            byte_data_r  <= '0;
            stop_err_evt <= 1'b0;
        end else begin
            byte_valid_r <= 1'b0;
            stop_err_evt <= 1'b0;
            if (!rx_active) begin
                if (start_edge) begin
                    rx_active <= 1'b1;
                    clk_cnt   <= '0;
                    bit_idx   <= '0;
                end
            end else begin
                if (clk_cnt == CNT_W'(BPS_CNT - 1)) begin
                    clk_cnt <= '0;
                    bit_idx <= bit_idx + 4'd1;
                end else begin
                    clk_cnt <= clk_cnt + 1'b1;
                end
                if (clk_cnt == CNT_W'(MID)) begin
                    if (bit_idx == 4'd0) begin
                        if (rxd_s2) rx_active <= 1'b0;
                    end else if (bit_idx == 4'd9) begin
                        rx_active <= 1'b0;
                        if (rxd_s2) begin
                            byte_valid_r <= 1'b1;
                            byte_data_r  <= shift;
                        end else begin
                            stop_err_evt <= 1'b1;
                        end
                    end else begin
                        shift <= {rxd_s2, shift[7:1]};
                    end
                end
            end
        end
    end

    assign byte_evt = byte_valid_r | stop_err_evt;

    // A byte event takes priority over a coincident timeout.
    always_comb begin
        abort      = 1'b0;
        abort_code = 2'd0;
        if (stop_err_evt) begin
            abort      = (state != S_IDLE);
            abort_code = 2'd0;
        end else if (byte_valid_r) begin
            case (state)
`ifdef UART_FRAME_CRC_EN
                S_CRC: begin
                    abort      = (byte_data_r != crc);
                    abort_code = 2'd2;
                end
`endif
                S_TAIL: begin
                    abort      = (byte_data_r != TAIL);
                    abort_code = 2'd3;
                end
                default: ;
            endcase
        end else if (state != S_IDLE && to_cnt == TO_W'(TO_LIM - 1)) begin
            abort      = 1'b1;
            abort_code = 2'd1;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state         <= S_IDLE;
            idx           <= '0;
            to_cnt        <= '0;
            shadow        <= '0;
            payload_r     <= '0;
            frame_valid_r <= 1'b0;
            frame_err_r   <= 1'b0;
            err_code_r    <= '0;
            err_cnt_r     <= '0;
`ifdef UART_FRAME_CRC_EN
            crc           <= '0;
`endif
        end else begin
            frame_valid_r <= 1'b0;
            frame_err_r   <= 1'b0;
            // Counter includes the strobe cycle, so the abort lands TO_LIM cycles after byte_valid.
            if (byte_evt)
                to_cnt <= TO_W'(1);
            else if (abort || state == S_IDLE)
                to_cnt <= '0;
            else
                to_cnt <= to_cnt + 1'b1;

            if (abort) begin
                state       <= S_IDLE;
                frame_err_r <= 1'b1;
                err_code_r  <= abort_code;
                if (err_cnt_r != 8'hFF) err_cnt_r <= err_cnt_r + 8'd1;
            end else if (byte_valid_r) begin
                case (state)
                    S_IDLE: begin
                        if (byte_data_r == HEADER) begin
                            state <= S_PAYLOAD;
                            idx   <= '0;
`ifdef UART_FRAME_CRC_EN
                            crc   <= '0;
`endif
                        end
                    end
                    S_PAYLOAD: begin
                        shadow[{idx, 3'b000} +: 8] <= byte_data_r;
`ifdef UART_FRAME_CRC_EN
                        crc <= crc8_step(crc, byte_data_r);
`endif
                        if (idx == IDX_W'(PAYLOAD_LEN - 1)) begin
`ifdef UART_FRAME_CRC_EN
                            state <= S_CRC;
`else
                            state <= S_TAIL;
`endif
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
`ifdef UART_FRAME_CRC_EN
                    S_CRC: state <= S_TAIL;
`endif
                    S_TAIL: begin
                        payload_r     <= shadow;
                        frame_valid_r <= 1'b1;
                        state         <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.byte_data   = byte_data_r;
    assign bus.byte_valid  = byte_valid_r;
    assign bus.payload     = payload_r;
    assign bus.frame_valid = frame_valid_r;
    assign bus.frame_err   = frame_err_r;
    assign bus.err_code    = err_code_r;
    assign bus.err_cnt     = err_cnt_r;
    assign bus.busy        = (state != S_IDLE);
    assign bus.frame_state = state;
endmodule

// File: tb/tb_uart_frame_rx.sv
// Self-checking bench for uart_frame_rx: directed frames, scoreboard queues, negedge monitor.
`timescale 1ns/1ps
module tb_uart_frame_rx;
  localparam int CLK_FREQ = 1_600_000;
  localparam int UART_BPS = 100_000;
  localparam int BPS      = 16;
  localparam int PLEN     = 9;
  localparam int TO_BITS  = 20;
  localparam int PW       = 8 * PLEN;
  localparam int EW       = 2 + 2 + 8 + PW;

  localparam logic [PW-1:0] PL1 = 72'h393837363534333231;
  localparam logic [PW-1:0] PL2 = 72'h7F8001A55AFF00AA55;

  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b0;

  uart_frame_rx_if #(.PAYLOAD_LEN(PLEN)) bus ();

  uart_frame_rx #(
    .CLK_FREQ(CLK_FREQ), .UART_BPS(UART_BPS), .PAYLOAD_LEN(PLEN),
    .HEADER(8'h55), .TAIL(8'hAA), .TIMEOUT_BITS(TO_BITS)
  ) dut (
    .sys_clk(sys_clk),
    .sys_rst_n(sys_rst_n),
    .bus(bus)
  );

  // clock / reset
  always #5 sys_clk = ~sys_clk;

  // scoreboard state: entry = {kind(1 ok, 2 err), code, err_cnt, payload}
  logic [EW-1:0] exp_q[$];
  logic [7:0]    exp_byte_q[$];
  logic [PW-1:0] exp_payload = '0;
  logic [7:0]    exp_err_cnt = '0;
  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] crc8_model(input logic [PW-1:0] pl);
    logic [7:0] c;
    logic fb;
    c = 8'h00;
    for (int i = 0; i < PLEN; i++) begin
      for (int b = 7; b >= 0; b--) begin
        fb = c[7] ^ pl[i*8+b];
        c = {c[6:0], 1'b0};
        if (fb) c = c ^ 8'h07;
      end
    end
    return c;
  endfunction

  // driver tasks
  task automatic bit_time(input logic v);
    @(negedge sys_clk);
    bus.uart_rxd = v;
    repeat (BPS - 1) @(negedge sys_clk);
  endtask

  task automatic idle_bits(input int n);
    for (int i = 0; i < n; i++) bit_time(1'b1);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    if (stop_bit) exp_byte_q.push_back(b);
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(b[i]);
    bit_time(stop_bit);
  endtask

  task automatic send_frame(input logic [PW-1:0] pl, input logic [7:0] crc_b, input logic [7:0] tail_b);
    send_byte(8'h55, 1'b1);
    for (int i = 0; i < PLEN; i++) send_byte(pl[i*8 +: 8], 1'b1);
`ifdef UART_FRAME_CRC_EN
    send_byte(crc_b, 1'b1);
`else
    if (crc_b == 8'h00 && tail_b == 8'h00) $display("note: empty crc/tail");
`endif
    send_byte(tail_b, 1'b1);
  endtask

  task automatic push_ok(input logic [PW-1:0] pl);
    exp_payload = pl;
    exp_q.push_back({2'd1, 2'd0, exp_err_cnt, pl});
  endtask

  task automatic push_err(input logic [1:0] code);
    if (exp_err_cnt != 8'hFF) exp_err_cnt = exp_err_cnt + 8'd1;
    exp_q.push_back({2'd2, code, exp_err_cnt, exp_payload});
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_byte_valid"}, bus.byte_valid, 0);
    check({tag, "_byte_data"}, bus.byte_data, 0);
    check({tag, "_payload"}, bus.payload, 0);
    check({tag, "_frame_valid"}, bus.frame_valid, 0);
    check({tag, "_frame_err"}, bus.frame_err, 0);
    check({tag, "_err_code"}, bus.err_code, 0);
    check({tag, "_err_cnt"}, bus.err_cnt, 0);
    check({tag, "_busy"}, bus.busy, 0);
  endtask

  // monitor: pops expectations whenever the DUT strobes
  initial begin : monitor
    longint cyc;
    longint last_bv;
    logic [EW-1:0] e;
    logic [7:0] eb;
    cyc = 0;
    last_bv = 0;
    forever begin
      @(negedge sys_clk);
      cyc++;
      if (bus.byte_valid) begin
        last_bv = cyc;
        if (exp_byte_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL byte_unexpected actual=%0h required=none", bus.byte_data);
        end else begin
          eb = exp_byte_q.pop_front();
          check("byte_data", bus.byte_data, eb);
        end
      end
      if (bus.frame_valid || bus.frame_err) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL frame_unexpected actual fv=%b fe=%b code=%0d required=no strobe",
                   bus.frame_valid, bus.frame_err, bus.err_code);
        end else begin
          e = exp_q.pop_front();
          check("strobe_kind", {bus.frame_err, bus.frame_valid}, e[EW-1 -: 2]);
          if (e[EW-1 -: 2] == 2'd2) begin
            check("err_code", bus.err_code, e[EW-3 -: 2]);
            if (e[EW-3 -: 2] == 2'd1) check("timeout_delay", cyc - last_bv, TO_BITS * BPS);
          end
          check("err_cnt", bus.err_cnt, e[PW+7 -: 8]);
          check("payload", bus.payload, e[PW-1:0]);
        end
      end
    end
  end

  // stimulus
  initial begin
    logic [7:0] crc1;
    logic [7:0] crc2;
    crc1 = 8'hF4;
    crc2 = crc8_model(PL2);
    bus.uart_rxd = 1'b1;
    sys_rst_n = 1'b0;
    repeat (5) @(negedge sys_clk);
    check_outputs_zero("reset");
    sys_rst_n = 1'b1;
    idle_bits(2);

    // good frame
    push_ok(PL1);
    send_frame(PL1, crc1, 8'hAA);

`ifdef UART_FRAME_CRC_EN
    // bad CRC then the good frame again, zero gap
    push_err(2'd2);
    send_frame(PL1, 8'hF5, 8'hAA);
`endif
    push_ok(PL1);
    send_frame(PL1, crc1, 8'hAA);

    // noise bytes in IDLE, then a frame whose payload holds header/tail values
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    send_byte(8'h12, 1'b1);
    push_ok(PL2);
    send_frame(PL2, crc2, 8'hAA);

    // short low glitch before the header must not produce a byte
    @(negedge sys_clk);
    bus.uart_rxd = 1'b0;
    repeat (4) @(negedge sys_clk);
    bus.uart_rxd = 1'b1;
    idle_bits(2);
    push_ok(PL1);
    send_frame(PL1, crc1, 8'hAA);

    // inter-byte timeout after the 4th payload byte
    push_err(2'd1);
    send_byte(8'h55, 1'b1);
    for (int i = 0; i < 4; i++) send_byte(PL1[i*8 +: 8], 1'b1);
    repeat (TO_BITS * BPS + 3 * BPS) @(negedge sys_clk);
    check("busy_after_timeout", bus.busy, 0);
    push_ok(PL1);
    send_frame(PL1, crc1, 8'hAA);

    // stop-bit error on payload byte 2
    push_err(2'd0);
    send_byte(8'h55, 1'b1);
    send_byte(PL2[7:0], 1'b1);
    send_byte(PL2[15:8], 1'b1);
    send_byte(PL2[23:16], 1'b0);
    idle_bits(3);
    check("busy_after_stop_err", bus.busy, 0);
    check("state_after_stop_err", bus.frame_state, 0);

    // wrong tail
    push_err(2'd3);
    send_frame(PL2, crc2, 8'hAB);
    idle_bits(2);
    check("busy_after_tail_err", bus.busy, 0);

    // reset in the middle of a payload
    send_byte(8'h55, 1'b1);
    send_byte(PL2[7:0], 1'b1);
    send_byte(PL2[15:8], 1'b1);
    check("busy_mid_payload", bus.busy, 1);
    @(negedge sys_clk);
    sys_rst_n = 1'b0;
    repeat (3) @(negedge sys_clk);
    check_outputs_zero("midreset");
    exp_payload = '0;
    exp_err_cnt = '0;
    sys_rst_n = 1'b1;
    idle_bits(4);
    push_ok(PL1);
    send_frame(PL1, crc1, 8'hAA);

    // drain, bounded
    for (int i = 0; i < 20 * BPS; i++) begin
      if (exp_q.size() == 0 && exp_byte_q.size() == 0) break;
      @(negedge sys_clk);
    end
    check("frame_queue_drained", exp_q.size(), 0);
    check("byte_queue_drained", exp_byte_q.size(), 0);
    check("final_payload", bus.payload, PL1);
    check("final_err_cnt", bus.err_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
